button_counter_multi: RTL and testbench

- Multi-channel button event counter: successor to the single-button edge counter, fully synchronous to the system clock instead of clocking registers from the raw button pin.
- Per channel:
  - synchronizes the asynchronous button input;
  - debounces it;
  - detects the selected edge type;
  - drives a parametrised-width counter that wraps or saturates.
- Sits between board push-buttons and LED/status logic.

---
 rtl/button_counter_multi.sv | 53 +++++
 tb/tb_button_counter_multi.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/button_counter_multi.sv
// button_counter_multi: per-channel synchronizer, debouncer, edge detector and wrap/saturate counter
module button_counter_multi #(
  parameter int CHANNELS = 2,
  parameter int CNT_W = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int EDGE_MODE = 0,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       btn_in,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS-1:0]       btn_level,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       wrap,
  output logic [CHANNELS*CNT_W-1:0] count_out
);
  localparam int DW = $clog2(DEBOUNCE_CYC);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0] dcnt;
    logic [CNT_W-1:0] cnt;
    logic level, pulse_r, wrap_r, s, flip, ev, at_max;
    assign s = sync[SYNC_STAGES-1];
    assign flip = (s != level) && (dcnt == DW'(DEBOUNCE_CYC - 1));
    // s is the level being adopted, so s=1 means a rising edge
    assign ev = flip && ((EDGE_MODE == 2) || ((EDGE_MODE == 0) == s));
    assign at_max = cnt == '1;
    always_ff @(posedge clk) begin
      if (rst) begin
        sync <= '0;
        dcnt <= '0;
        level <= 1'b0;
        pulse_r <= 1'b0;
        wrap_r <= 1'b0;
        cnt <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], btn_in[c]};
        dcnt <= (s == level || flip) ? '0 : dcnt + DW'(1);
        if (flip) level <= s;
        pulse_r <= ev;
        wrap_r <= !clr[c] && ev && en && at_max;
        cnt <= clr[c] ? '0 : (ev && en) ? ((at_max && SATURATE != 0) ? cnt : cnt + CNT_W'(1)) : cnt;
      end
    end
    assign btn_level[c] = level;
    assign pulse[c] = pulse_r;
    assign wrap[c] = wrap_r;
    assign count_out[c*CNT_W +: CNT_W] = cnt;
  end
endmodule

// File: tb/tb_button_counter_multi.sv
// tb_button_counter_multi: directed checks across default, saturating and edge-mode variants
module tb_button_counter_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic [1:0] btn_in = 2'b00;
  logic [1:0] clr = 2'b00;
  logic [1:0] lvl [4];
  logic [1:0] pls [4];
  logic [1:0] wrp [4];
  logic [7:0] cnt [4];
  int pc [4][2];
  int wc [4][2];
  int fc;
  int checks = 0;
  int errors = 0;
  int p0, p1, w0, w1;
  always #5 clk = ~clk;
  button_counter_multi u0 (.clk(clk), .rst(rst), .btn_in(btn_in), .en(en), .clr(clr),
    .btn_level(lvl[0]), .pulse(pls[0]), .wrap(wrp[0]), .count_out(cnt[0]));
  button_counter_multi #(.SATURATE(1)) u1 (.clk(clk), .rst(rst), .btn_in(btn_in), .en(en), .clr(clr),
    .btn_level(lvl[1]), .pulse(pls[1]), .wrap(wrp[1]), .count_out(cnt[1]));
  button_counter_multi #(.EDGE_MODE(2)) u2 (.clk(clk), .rst(rst), .btn_in(btn_in), .en(en), .clr(clr),
    .btn_level(lvl[2]), .pulse(pls[2]), .wrap(wrp[2]), .count_out(cnt[2]));
  button_counter_multi #(.EDGE_MODE(1)) u3 (.clk(clk), .rst(rst), .btn_in(btn_in), .en(en), .clr(clr),
    .btn_level(lvl[3]), .pulse(pls[3]), .wrap(wrp[3]), .count_out(cnt[3]));
  initial begin
    for (int k = 0; k < 4; k++) for (int c = 0; c < 2; c++) begin pc[k][c] = 0; wc[k][c] = 0; end
    fc = 0;
  end
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 2; c++) begin
        if (pls[k][c] === 1'b1) pc[k][c]++;
        if (wrp[k][c] === 1'b1) wc[k][c]++;
      end
    if (pls[3][0] === 1'b1 && lvl[3][0] === 1'b0) fc++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1; btn_in = 2'b00; clr = 2'b00; en = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
  endtask
  task automatic press(input int ch);
    btn_in[ch] = 1'b1;
    cyc(25);
    btn_in[ch] = 1'b0;
    cyc(25);
  endtask
  initial begin
    // reset with both buttons held
    btn_in = 2'b11;
    cyc(3);
    check("rst_level", 32'(lvl[0]), 0);
    check("rst_pulse", 32'(pls[0]), 0);
    check("rst_wrap", 32'(wrp[0]), 0);
    check("rst_count", 32'(cnt[0]), 0);
    rst = 1'b0;
    cyc(17);
    check("held_level_before", 32'(lvl[0]), 0);
    cyc(1);
    check("held_level_at17", 32'(lvl[0]), 3);
    check("held_pulse_at17", 32'(pls[0]), 3);
    check("held_count_at17", 32'(cnt[0]), 32'h11);
    cyc(1);
    check("held_pulse_one_cycle", 32'(pls[0]), 0);
    // bounce on ch0, 15-cycle glitch on ch1
    do_reset();
    p0 = pc[0][0];
    for (int i = 0; i < 12; i++) begin btn_in[0] = ~btn_in[0]; cyc(5); end
    check("bounce_level", 32'(lvl[0][0]), 0);
    btn_in[0] = 1'b1;
    cyc(25);
    check("bounce_pulses", 32'(pc[0][0] - p0), 1);
    check("bounce_count", 32'(cnt[0][3:0]), 1);
    p1 = pc[0][1];
    btn_in[1] = 1'b1; cyc(15); btn_in[1] = 1'b0; cyc(25);
    check("glitch15_pulses", 32'(pc[0][1] - p1), 0);
    check("glitch15_count", 32'(cnt[0][7:4]), 0);
    // wrap vs saturate on ch1
    do_reset();
    w0 = wc[0][1]; w1 = wc[1][1];
    for (int i = 1; i <= 17; i++) begin
      press(1);
      check("wrap_cnt_default", 32'(cnt[0][7:4]), 32'(i % 16));
      check("wrap_cnt_saturate", 32'(cnt[1][7:4]), 32'(i > 15 ? 15 : i));
      if (i == 15) begin
        check("wraps_default_15", 32'(wc[0][1] - w0), 0);
        check("wraps_saturate_15", 32'(wc[1][1] - w1), 0);
      end
      if (i == 16) begin
        check("wraps_default_16", 32'(wc[0][1] - w0), 1);
        check("wraps_saturate_16", 32'(wc[1][1] - w1), 1);
      end
    end
    check("wraps_default_17", 32'(wc[0][1] - w0), 1);
    check("wraps_saturate_17", 32'(wc[1][1] - w1), 2);
    // edge modes
    do_reset();
    p0 = pc[2][0]; p1 = pc[3][0]; w0 = fc;
    for (int i = 0; i < 3; i++) press(0);
    check("both_pulses", 32'(pc[2][0] - p0), 6);
    check("both_count", 32'(cnt[2][3:0]), 6);
    check("fall_pulses", 32'(pc[3][0] - p1), 3);
    check("fall_on_release", 32'(fc - w0), 3);
    check("fall_count", 32'(cnt[3][3:0]), 3);
    check("rise_count", 32'(cnt[0][3:0]), 3);
    // clear coincident with an event
    do_reset();
    for (int i = 0; i < 2; i++) press(1);
    for (int i = 0; i < 7; i++) press(0);
    btn_in[0] = 1'b1;
    cyc(17);
    check("clr_pre_count", 32'(cnt[0][3:0]), 7);
    clr = 2'b01;
    cyc(1);
    clr = 2'b00;
    check("clr_pulse", 32'(pls[0][0]), 1);
    check("clr_count", 32'(cnt[0][3:0]), 0);
    check("clr_wrap", 32'(wrp[0][0]), 0);
    check("clr_ch1_count", 32'(cnt[0][7:4]), 2);
    btn_in[0] = 1'b0;
    cyc(25);
    // enable gating on ch1
    en = 1'b0;
    p1 = pc[0][1];
    for (int i = 0; i < 4; i++) press(1);
    check("en0_pulses", 32'(pc[0][1] - p1), 4);
    check("en0_count", 32'(cnt[0][7:4]), 2);
    en = 1'b1;
    press(1);
    check("en1_count", 32'(cnt[0][7:4]), 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
